// File: rtl/proctimers_n.sv
// rtl/proctimers_n.sv - multi-channel periodic process timer with sticky ready/overrun flags
module proctimers_n #(
    parameter int num_chan  = 8,
    parameter int cnt_width = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic        tick,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq
);

    logic [cnt_width-1:0] period    [num_chan];
    logic [cnt_width-1:0] cnt       [num_chan];
    logic [cnt_width-1:0] period_nx [num_chan];
    logic [cnt_width-1:0] cnt_nx    [num_chan];
    logic [num_chan-1:0]  rdy, ovr, rdy_nx, ovr_nx;

    logic                 cfg_wr, ack_wr, restart_wr;
    logic [4:0]           ch;
    logic [cnt_width-1:0] per;
    logic [num_chan-1:0]  clr;
    logic                 unused_bits;

    assign cfg_wr      = stb & we & ~addr;
    assign ack_wr      = stb & we & addr & ~data_in[31];
    assign restart_wr  = stb & we & addr & data_in[31];
    assign ch          = data_in[20:16];
    assign per         = data_in[cnt_width-1:0];
    assign clr         = data_in[num_chan-1:0] & {num_chan{ack_wr}};
    assign unused_bits = ^data_in;

    // Per-channel next state: a write to a channel beats its tick; an
    // acknowledge in the same cycle as a fire leaves ready set but blocks overrun.
    always_comb begin
        for (int i = 0; i < num_chan; i++) begin
            period_nx[i] = period[i];
            cnt_nx[i]    = cnt[i];
            rdy_nx[i]    = rdy[i] & ~clr[i];
            ovr_nx[i]    = ovr[i] & ~clr[i];
            if (cfg_wr && (ch == 5'(i))) begin
                period_nx[i] = per;
                cnt_nx[i]    = per;
                rdy_nx[i]    = 1'b0;
                ovr_nx[i]    = 1'b0;
            end else if (restart_wr) begin
                cnt_nx[i]    = period[i];
                rdy_nx[i]    = 1'b0;
                ovr_nx[i]    = 1'b0;
            end else if (tick && (period[i] != '0)) begin
                if (cnt[i] == cnt_width'(1)) begin
                    cnt_nx[i] = period[i];
                    rdy_nx[i] = 1'b1;
                    if (rdy[i] && !clr[i]) begin
                        ovr_nx[i] = 1'b1;
                    end
                end else begin
                    cnt_nx[i] = cnt[i] - cnt_width'(1);
                end
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < num_chan; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
            rdy <= '0;
            ovr <= '0;
        end else begin
            for (int i = 0; i < num_chan; i++) begin
                period[i] <= period_nx[i];
                cnt[i]    <= cnt_nx[i];
            end
            rdy <= rdy_nx;
            ovr <= ovr_nx;
        end
    end

    // Zero-wait-state read mux; bus reads zero when not selected.
    always_comb begin
        data_out = '0;
        if (stb) begin
            data_out[num_chan-1:0] = addr ? ovr : rdy;
        end
    end

    assign ack = stb;
    assign irq = |rdy;

endmodule

// File: tb/tb_proctimers_n.sv
// tb/tb_proctimers_n.sv - directed table-driven bench for proctimers_n
module tb_proctimers_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic        addr = 1'b0;
    logic        tick = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out, data_out31;
    logic        ack, ack31, irq, irq31;

    int n_total = 0;
    int n_pass  = 0;

    localparam int OP_W  = 0;
    localparam int OP_WT = 1;
    localparam int OP_T  = 2;
    localparam int OP_R  = 3;
    localparam int OP_I  = 4;

    typedef struct {
        int          op;
        logic        a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    proctimers_n dut (
        .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr), .tick(tick),
        .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq)
    );

    proctimers_n #(.num_chan(31), .cnt_width(16)) dut31 (
        .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr), .tick(tick),
        .data_in(data_in), .data_out(data_out31), .ack(ack31), .irq(irq31)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    endtask

    task automatic bus_write(input logic a, input logic [31:0] d, input logic with_tick);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d; tick = with_tick;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0; data_in = '0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic bus_read(input logic a, output logic [31:0] v, output logic [31:0] v31, output logic k);
        stb = 1'b1; we = 1'b0; addr = a;
        #1;
        v = data_out; v31 = data_out31; k = ack;
        stb = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) begin
            tick = ~tick;
            @(posedge clk);
        end
        #1 rst_n = 1'b1; tick = 1'b0;
    endtask

    function automatic void add(input int op, input logic a, input logic [31:0] d, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.exp = exp;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [31:0] v, v31;
        logic        k;

        // reset state
        @(posedge clk); #1;
        do_reset();
        bus_read(1'b0, v, v31, k);
        check("reset_rdy", v, 32'h0);
        check("reset_ack", {31'b0, k}, 32'h1);
        bus_read(1'b1, v, v31, k);
        check("reset_ovr", v, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        #1 check("idle_bus_zero", data_out, 32'h0);

        // channel 3 period 5, channel 2 disabled
        add(OP_W, 0, 32'h0003_0005, 0); add(OP_W, 0, 32'h0002_0000, 0);
        add(OP_T, 0, 4, 0); add(OP_R, 0, 0, 32'h0); add(OP_I, 0, 0, 0);
        add(OP_T, 0, 1, 0); add(OP_R, 0, 0, 32'h08); add(OP_I, 0, 0, 1); add(OP_R, 1, 0, 32'h0);
        add(OP_W, 1, 32'h08, 0); add(OP_R, 0, 0, 32'h0); add(OP_I, 0, 0, 0);
        add(OP_T, 0, 4, 0); add(OP_R, 0, 0, 32'h0); add(OP_T, 0, 1, 0); add(OP_R, 0, 0, 32'h08);
        add(OP_W, 0, 32'h0003_0000, 0); add(OP_R, 0, 0, 32'h0);
        // channel 0 period 1: fire, overrun, acknowledge
        add(OP_W, 0, 32'h0000_0001, 0);
        add(OP_T, 0, 1, 0); add(OP_R, 0, 0, 32'h1); add(OP_R, 1, 0, 32'h0);
        add(OP_T, 0, 1, 0); add(OP_R, 1, 0, 32'h1); add(OP_R, 0, 0, 32'h1);
        add(OP_W, 1, 32'h1, 0); add(OP_R, 0, 0, 32'h0); add(OP_R, 1, 0, 32'h0);
        // acknowledge coinciding with a fire
        add(OP_T, 0, 1, 0); add(OP_R, 0, 0, 32'h1);
        add(OP_WT, 1, 32'h1, 0); add(OP_R, 0, 0, 32'h1); add(OP_R, 1, 0, 32'h0);
        add(OP_T, 0, 1, 0); add(OP_R, 1, 0, 32'h1);
        // in-phase restart
        add(OP_W, 0, 32'h0000_0003, 0); add(OP_W, 0, 32'h0001_0006, 0); add(OP_W, 0, 32'h0004_0001, 0);
        add(OP_T, 0, 2, 0); add(OP_R, 0, 0, 32'h10); add(OP_R, 1, 0, 32'h10);
        add(OP_W, 1, 32'h8000_0000, 0); add(OP_R, 0, 0, 32'h0); add(OP_R, 1, 0, 32'h0);
        add(OP_T, 0, 1, 0); add(OP_R, 0, 0, 32'h10);
        add(OP_T, 0, 1, 0); add(OP_R, 0, 0, 32'h10); add(OP_R, 1, 0, 32'h10);
        add(OP_T, 0, 1, 0); add(OP_R, 0, 0, 32'h11);
        add(OP_T, 0, 2, 0); add(OP_R, 0, 0, 32'h11);
        add(OP_T, 0, 1, 0); add(OP_R, 0, 0, 32'h13); add(OP_R, 1, 0, 32'h11);
        // out-of-range channel is ignored
        add(OP_W, 0, 32'h001F_0001, 0); add(OP_R, 0, 0, 32'h13); add(OP_R, 1, 0, 32'h11);

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_W:  bus_write(tbl[i].a, tbl[i].d, 1'b0);
                OP_WT: bus_write(tbl[i].a, tbl[i].d, 1'b1);
                OP_T:  ticks(int'(tbl[i].d));
                OP_R: begin
                    bus_read(tbl[i].a, v, v31, k);
                    check($sformatf("vec%0d_read%0d", i, tbl[i].a), v, tbl[i].exp);
                end
                default: check($sformatf("vec%0d_irq", i), {31'b0, irq}, tbl[i].exp);
            endcase
        end

        // reset mid-count aborts everything and channels stay disabled
        do_reset();
        bus_read(1'b0, v, v31, k);
        check("midreset_rdy", v, 32'h0);
        bus_read(1'b1, v, v31, k);
        check("midreset_ovr", v, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        ticks(5);
        bus_read(1'b0, v, v31, k);
        check("post_reset_idle", v, 32'h0);

        // 31-channel instance, full-width period on the top channel
        bus_write(1'b0, 32'h001E_FFFF, 1'b0);
        ticks(65534);
        bus_read(1'b0, v, v31, k);
        check("wide_before_fire", v31, 32'h0);
        check("narrow_ignores_ch30", v, 32'h0);
        ticks(1);
        bus_read(1'b0, v, v31, k);
        check("wide_fire", v31, 32'h4000_0000);
        check("wide_irq", {31'b0, irq31}, 32'h1);
        bus_read(1'b1, v, v31, k);
        check("wide_ovr", v31, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
